// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame state encoding and line constants.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   UART_OVERSAMPLE = 16;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/baud/line bundle for the shared UART transmitter.
// The master side drives requests and the baud enable; the slave side is the scheduler.
`timescale 1ns/1ps
interface uart_tx_scheduler_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 req0;
    logic [DATA_BITS-1:0] data0;
    logic                 ack0;
    logic                 req1;
    logic [DATA_BITS-1:0] data1;
    logic                 ack1;
    logic                 txd;
    logic                 busy;
    logic                 grant_id;

    modport master (
        output baud_tick, req0, data0, req1, data1,
        input  ack0, ack1, txd, busy, grant_id
    );

    modport slave (
        input  baud_tick, req0, data0, req1, data1,
        output ack0, ack1, txd, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_scheduler_arbiter.sv
// Two-way round-robin arbiter. The pointer remembers who was served last so
// that on simultaneous requests the other requester wins. Out of reset the
// pointer marks requester 1 as last served, so requester 0 is favoured.
`timescale 1ns/1ps
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last;

    // One-hot grant: single requester wins outright, a tie goes to the one not served last.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Pointer moves only when the scheduler actually accepts the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line between two requesters, one frame per grant.
// Frame: start bit, DATA_BITS data LSB first, optional even parity, STOP_BITS stop bits.
// Bit timing is OVERSAMPLE baud_tick enables per bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data.
`timescale 1ns/1ps
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_scheduler_if.slave   bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;

    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 txd_r;
    logic                 busy_r;
    logic                 grant_id_r;
    logic [1:0]           grant;
    logic                 idle;
    logic                 accept;
    logic                 bit_end;
    logic [DATA_BITS-1:0] win_data;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({bus.req1, bus.req0}),
        .accept (accept),
        .grant  (grant)
    );

    assign idle     = (state == S_IDLE);
    // Grant is taken in the same cycle the request is seen while idle; ack is that cycle.
    assign accept   = rst_n && idle && (grant != 2'b00);
    assign win_data = grant[1] ? bus.data1 : bus.data0;
    assign bit_end  = bus.baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

    assign bus.ack0     = accept && grant[0];
    assign bus.ack1     = accept && grant[1];
    assign bus.txd      = txd_r;
    assign bus.busy     = busy_r;
    assign bus.grant_id = grant_id_r;

    // Oversample tick counter: restarts at grant so the start bit spans a full bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (accept) begin
            tick_cnt <= '0;
        end else if (!idle && bus.baud_tick) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
        end
    end

    // Payload capture at grant and LSB-first shifting at each data bit end.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift <= win_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^win_data;
`endif
        end else if ((state == S_DATA) && bit_end) begin
            shift <= shift >> 1;
        end
    end

    // Frame sequencer; txd and busy are registered so they change on the edge after a decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            txd_r      <= UART_IDLE_LEVEL;
            busy_r     <= 1'b0;
            grant_id_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_START;
                        txd_r      <= ~UART_IDLE_LEVEL;
                        busy_r     <= 1'b1;
                        grant_id_r <= grant[1];
                        bit_cnt    <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        txd_r   <= shift[0];
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
                            txd_r   <= parity_bit;
`else
                            state   <= S_STOP;
                            txd_r   <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd_r   <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        txd_r   <= UART_IDLE_LEVEL;
                        bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state   <= S_IDLE;
                            busy_r  <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    txd_r   <= UART_IDLE_LEVEL;
                    busy_r  <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected frames/acks,
// independent monitors decode the serial line and the ack pulses.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int STOP_BITS  = 1;
    localparam int TICK_DIV   = 5;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

    typedef struct {
        int                   id;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t frame_q[$];
    int   ack_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   rr_last = 1;

    uart_tx_scheduler_if #(.DATA_BITS(DATA_BITS)) bus();

    uart_tx_scheduler #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .STOP_BITS  (STOP_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        bus.baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c = (c + 1) % TICK_DIV;
            bus.baud_tick = (c == 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_parity(input logic [DATA_BITS-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < DATA_BITS; i++) if (d[i]) ones++;
        return (ones % 2) == 1;
    endfunction

    // Winner for a given set of simultaneous requests under round-robin fairness.
    function automatic int model_pick(input bit r0, input bit r1);
        if (r0 && r1) return (rr_last == 1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    task automatic expect_frame(input int id, input logic [DATA_BITS-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        frame_q.push_back(e);
        ack_q.push_back(id);
        rr_last = id;
    endtask

    task automatic wait_neg(input int n, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst_n) begin
                aborted = 1'b1;
                return;
            end
        end
    endtask

    // Ack monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (bus.ack0 || bus.ack1)) begin
                check("ack_exclusive", 32'(bus.ack0 && bus.ack1), 32'd0);
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected no ack", bus.ack0, bus.ack1);
                end else begin
                    int e;
                    e = ack_q.pop_front();
                    check("ack_id", 32'(bus.ack1), 32'(e));
                end
            end
        end
    end

    // Serial line monitor: mid-bit sampling relative to the start-bit falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.txd === 1'b0) begin
                exp_t                 e;
                bit                   ab;
                logic [DATA_BITS-1:0] got;
                int                   c;
                bit                   found;
                ab    = 1'b0;
                got   = '0;
                found = 1'b0;
                if (frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_frame: got txd=0 expected idle line");
                    wait_neg(FRAME_BITS * BIT_CLKS + 10, ab);
                end else begin
                    e = frame_q.pop_front();
                    check("grant_id", 32'(bus.grant_id), 32'(e.id));
                    check("busy_in_frame", 32'(bus.busy), 32'd1);
                    wait_neg(BIT_CLKS / 2 - 1, ab);
                    if (!ab) check("start_bit", 32'(bus.txd), 32'd0);
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (!ab) begin
                            wait_neg(BIT_CLKS, ab);
                            if (!ab) got[i] = bus.txd;
                        end
                    end
                    if (!ab) check("data", 32'(got), 32'(e.data));
`ifdef UART_TX_PARITY_EN
                    if (!ab) begin
                        wait_neg(BIT_CLKS, ab);
                        if (!ab) check("parity_bit", 32'(bus.txd), 32'(model_parity(e.data)));
                    end
`endif
                    for (int s = 0; s < STOP_BITS; s++) begin
                        if (!ab) begin
                            wait_neg(BIT_CLKS, ab);
                            if (!ab) check("stop_bit", 32'(bus.txd), 32'd1);
                        end
                    end
                    if (!ab) begin
                        c = BIT_CLKS / 2 - 1 + BIT_CLKS * (FRAME_BITS - 1);
                        for (int k = 0; k < 80; k++) begin
                            wait_neg(1, ab);
                            if (ab) break;
                            c++;
                            if (!bus.busy) begin
                                found = 1'b1;
                                break;
                            end
                        end
                        if (!ab) begin
                            check("busy_fall", 32'(found), 32'd1);
                            check("frame_length",
                                  32'((c >= FRAME_BITS * BIT_CLKS - 10) && (c <= FRAME_BITS * BIT_CLKS + 5)),
                                  32'd1);
                        end
                    end
                end
            end
        end
    end

    task automatic raise(input int id, input logic [DATA_BITS-1:0] d);
        if (id == 0) begin
            bus.req0  = 1'b1;
            bus.data0 = d;
        end else begin
            bus.req1  = 1'b1;
            bus.data1 = d;
        end
    endtask

    task automatic drop(input int id);
        if (id == 0) begin
            bus.req0  = 1'b0;
            bus.data0 = DATA_BITS'($urandom);
        end else begin
            bus.req1  = 1'b0;
            bus.data1 = DATA_BITS'($urandom);
        end
    endtask

    task automatic wait_ack(input int id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.ack0) || (id == 1 && bus.ack1)) begin
                seen = 1'b1;
                break;
            end
        end
        check("ack_arrived", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        drop(id);
    endtask

    task automatic wait_idle();
        bit fell;
        fell = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                fell = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(fell), 32'd1);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
    endtask

    task automatic do_single(input int id, input logic [DATA_BITS-1:0] d);
        raise(id, d);
        expect_frame(id, d);
        wait_ack(id);
        wait_idle();
    endtask

    task automatic do_both(input logic [DATA_BITS-1:0] d0, input logic [DATA_BITS-1:0] d1);
        int  w;
        int  l;
        bit  fell;
        w = model_pick(1'b1, 1'b1);
        l = 1 - w;
        raise(0, d0);
        raise(1, d1);
        expect_frame(w, (w == 0) ? d0 : d1);
        expect_frame(l, (l == 0) ? d0 : d1);
        wait_ack(w);
        fell = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                fell = 1'b1;
                break;
            end
        end
        check("first_frame_done", 32'(fell), 32'd1);
        check("regrant_after_busy_falls", 32'((l == 0) ? bus.ack0 : bus.ack1), 32'd1);
        @(posedge clk);
        #1;
        drop(l);
        wait_idle();
    endtask

    task automatic do_pulse(input logic [DATA_BITS-1:0] d);
        raise(0, d);
        expect_frame(0, d);
        wait_ack(0);
        repeat (100) @(posedge clk);
        #1;
        bus.req1  = 1'b1;
        bus.data1 = DATA_BITS'($urandom);
        repeat (3) @(posedge clk);
        #1;
        bus.req1 = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("line_idle_txd", 32'(bus.txd), 32'd1);
        check("line_idle_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_BITS-1:0] d;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;

        // Reset and idle line.
        #20;
        check("reset_txd", 32'(bus.txd), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_grant_id", 32'(bus.grant_id), 32'd0);
        check("reset_acks", 32'({bus.ack1, bus.ack0}), 32'd0);
        #3;
        rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        check("idle_txd", 32'(bus.txd), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Directed frames.
        do_both(8'hA5, 8'h3C);
        do_single(0, 8'h55);
`ifdef UART_TX_PARITY_EN
        do_single(0, 8'h07);
        do_single(0, 8'h03);
`endif
        do_pulse(8'hC3);
        do_single(1, 8'h00);
        do_single(0, 8'hFF);

        // Randomized traffic.
        for (int n = 0; n < 10; n++) begin
            int sc;
            sc = $urandom_range(0, 3);
            d  = DATA_BITS'($urandom);
            case (sc)
                0: do_single(0, d);
                1: do_single(1, d);
                2: do_both(d, DATA_BITS'($urandom));
                default: do_pulse(d);
            endcase
        end

        // Reset in the middle of data bit 4 aborts the frame immediately.
        d = DATA_BITS'($urandom);
        raise(0, d);
        expect_frame(0, d);
        wait_ack(0);
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_txd", 32'(bus.txd), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_grant_id", 32'(bus.grant_id), 32'd0);
        check("abort_acks", 32'({bus.ack1, bus.ack0}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        rr_last = 1;
        @(posedge clk);
        #1;
        do_single(1, DATA_BITS'($urandom));

        repeat (50) @(posedge clk);
        check("frames_all_seen", 32'(frame_q.size()), 32'd0);
        check("acks_all_seen", 32'(ack_q.size()), 32'd0);
        check("final_txd", 32'(bus.txd), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
